// File: rtl/zmc_seq.sv
// zmc_seq: instruction sequencer for the zmc_comp datapath.
// It accepts one decoded instruction per handshake and latches its fields.
// It then sequences reg-file writes, flag updates, segment loads and external
// load/store requests from those latched fields. Multi-cycle waits are bounded
// by a timeout counter.
module zmc_seq #(
  parameter int DATA_WL    = 16,
  parameter int OP_WL      = 8,
  parameter int SEG_REG_WL = 4,
  parameter int ADR_REG_WL = 4,
  parameter int TMO_WL     = 4
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic                  instr_valid_in,
  output logic                  instr_ready_out,
  input  logic [3:0]            instr_opc_in,
  input  logic [ADR_REG_WL-1:0] instr_a_in,
  input  logic [ADR_REG_WL-1:0] instr_b_in,
  input  logic [OP_WL-1:0]      instr_alu_op_in,
  input  logic [DATA_WL-1:0]    instr_imm_in,
  input  logic                  alu_valid_in,
  input  logic                  ext_ack_in,
  output logic [ADR_REG_WL-1:0] a_adr_out,
  output logic [ADR_REG_WL-1:0] b_adr_out,
  output logic [OP_WL-1:0]      alu_op_out,
  output logic                  reg_file_we_out,
  output logic                  flag_reg_ce_out,
  output logic [1:0]            alu_mux_sel_out,
  output logic [DATA_WL-1:0]    data_instr_out,
  output logic [SEG_REG_WL-1:0] seg_reg_out,
  output logic                  seg_reg_load_out,
  output logic                  ext_rd_req_out,
  output logic                  ext_wr_req_out,
  output logic                  done_out,
  output logic                  err_out
);

  localparam logic [3:0] OPC_NOP = 4'd0;
  localparam logic [3:0] OPC_ALU = 4'd1;
  localparam logic [3:0] OPC_LDI = 4'd2;
  localparam logic [3:0] OPC_CMP = 4'd3;
  localparam logic [3:0] OPC_SEG = 4'd4;
  localparam logic [3:0] OPC_LDX = 4'd5;
  localparam logic [3:0] OPC_STX = 4'd6;

  localparam logic [1:0] MUX_IMM = 2'd1;
  localparam logic [1:0] MUX_ALU = 2'd2;
  localparam logic [1:0] MUX_EXT = 2'd3;

  // Last waiting cycle before giving up: 2**TMO_WL-1.
  localparam logic [TMO_WL-1:0] TMO_LIM = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_ALU_WAIT, S_EXT_RD, S_EXT_WR
  } state_t;

  typedef struct packed {
    logic [3:0]            opc;
    logic [ADR_REG_WL-1:0] a;
    logic [ADR_REG_WL-1:0] b;
    logic [OP_WL-1:0]      op;
    logic [DATA_WL-1:0]    imm;
  } instr_t;

  state_t              state_q, state_d;
  instr_t              instr_q, instr_d;
  logic [TMO_WL-1:0]   tmo_q, tmo_d;
  logic                tmo_hit;

  // State, latched instruction and timeout counter; reset clears everything.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign tmo_hit = (tmo_q == TMO_LIM);

  // Next state and all control outputs from state plus latched fields.
  always_comb begin
    state_d          = state_q;
    instr_d          = instr_q;
    tmo_d            = tmo_q;
    instr_ready_out  = (state_q == S_IDLE);
    a_adr_out        = '0;
    b_adr_out        = '0;
    alu_op_out       = '0;
    reg_file_we_out  = 1'b0;
    flag_reg_ce_out  = 1'b0;
    alu_mux_sel_out  = '0;
    data_instr_out   = '0;
    seg_reg_out      = '0;
    seg_reg_load_out = 1'b0;
    ext_rd_req_out   = 1'b0;
    ext_wr_req_out   = 1'b0;
    done_out         = 1'b0;
    err_out          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_valid_in) begin
          instr_d = '{opc: instr_opc_in, a: instr_a_in, b: instr_b_in,
                      op: instr_alu_op_in, imm: instr_imm_in};
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        a_adr_out  = instr_q.a;
        b_adr_out  = instr_q.b;
        alu_op_out = instr_q.op;
        tmo_d      = '0;
        state_d    = S_IDLE;
        case (instr_q.opc)
          OPC_NOP: done_out = 1'b1;
          OPC_ALU: begin
            alu_mux_sel_out = MUX_ALU;
            reg_file_we_out = 1'b1;
            flag_reg_ce_out = 1'b1;
            if (instr_q.op[OP_WL-1]) state_d = S_ALU_WAIT;
            else                     done_out = 1'b1;
          end
          OPC_LDI: begin
            alu_mux_sel_out = MUX_IMM;
            data_instr_out  = instr_q.imm;
            reg_file_we_out = 1'b1;
            done_out        = 1'b1;
          end
          OPC_CMP: begin
            flag_reg_ce_out = 1'b1;
            done_out        = 1'b1;
          end
          OPC_SEG: begin
            seg_reg_out      = instr_q.b[SEG_REG_WL-1:0];
            seg_reg_load_out = 1'b1;
            done_out         = 1'b1;
          end
          OPC_LDX: state_d = S_EXT_RD;
          OPC_STX: state_d = S_EXT_WR;
          default: err_out = 1'b1;
        endcase
      end

      // Upper-word write of a long op; datapath forces a_adr LSB itself.
      S_ALU_WAIT: begin
        a_adr_out       = instr_q.a;
        b_adr_out       = instr_q.b;
        alu_op_out      = instr_q.op;
        alu_mux_sel_out = MUX_ALU;
        if (alu_valid_in) begin
          reg_file_we_out = 1'b1;
          done_out        = 1'b1;
          state_d         = S_IDLE;
        end else if (tmo_hit) begin
          alu_mux_sel_out = '0;
          err_out         = 1'b1;
          state_d         = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_EXT_RD: begin
        a_adr_out = instr_q.a;
        b_adr_out = instr_q.b;
        if (ext_ack_in) begin
          ext_rd_req_out  = 1'b1;
          alu_mux_sel_out = MUX_EXT;
          reg_file_we_out = 1'b1;
          done_out        = 1'b1;
          state_d         = S_IDLE;
        end else if (tmo_hit) begin
          err_out = 1'b1;
          state_d = S_IDLE;
        end else begin
          ext_rd_req_out  = 1'b1;
          alu_mux_sel_out = MUX_EXT;
          tmo_d           = tmo_q + 1'b1;
        end
      end

      // a_adr selects which register feeds data_out during the store.
      S_EXT_WR: begin
        a_adr_out = instr_q.a;
        b_adr_out = instr_q.b;
        if (ext_ack_in) begin
          ext_wr_req_out = 1'b1;
          done_out       = 1'b1;
          state_d        = S_IDLE;
        end else if (tmo_hit) begin
          err_out = 1'b1;
          state_d = S_IDLE;
        end else begin
          ext_wr_req_out = 1'b1;
          tmo_d          = tmo_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A reset cycle aborts the instruction: no side effect may escape it.
    if (s_reset) begin
      reg_file_we_out  = 1'b0;
      flag_reg_ce_out  = 1'b0;
      seg_reg_load_out = 1'b0;
      ext_rd_req_out   = 1'b0;
      ext_wr_req_out   = 1'b0;
      done_out         = 1'b0;
      err_out          = 1'b0;
    end
  end

endmodule

// File: tb/tb_zmc_seq.sv
// Bench for zmc_seq: a driver issues directed and random instructions. A
// reference model predicts each instruction's retirement summary into a
// queue, and a monitor accumulates observed activity per instruction and
// compares it at done/err.
module tb_zmc_seq;
  logic        clk = 1'b0;
  logic        s_reset;
  logic        instr_valid_in, instr_ready_out;
  logic [3:0]  instr_opc_in, instr_a_in, instr_b_in;
  logic [7:0]  instr_alu_op_in;
  logic [15:0] instr_imm_in;
  logic        alu_valid_in, ext_ack_in;
  logic [3:0]  a_adr_out, b_adr_out;
  logic [7:0]  alu_op_out;
  logic        reg_file_we_out, flag_reg_ce_out;
  logic [1:0]  alu_mux_sel_out;
  logic [15:0] data_instr_out;
  logic [3:0]  seg_reg_out;
  logic        seg_reg_load_out, ext_rd_req_out, ext_wr_req_out, done_out, err_out;

  zmc_seq dut (
    .clk(clk), .s_reset(s_reset),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .instr_opc_in(instr_opc_in), .instr_a_in(instr_a_in), .instr_b_in(instr_b_in),
    .instr_alu_op_in(instr_alu_op_in), .instr_imm_in(instr_imm_in),
    .alu_valid_in(alu_valid_in), .ext_ack_in(ext_ack_in),
    .a_adr_out(a_adr_out), .b_adr_out(b_adr_out), .alu_op_out(alu_op_out),
    .reg_file_we_out(reg_file_we_out), .flag_reg_ce_out(flag_reg_ce_out),
    .alu_mux_sel_out(alu_mux_sel_out), .data_instr_out(data_instr_out),
    .seg_reg_out(seg_reg_out), .seg_reg_load_out(seg_reg_load_out),
    .ext_rd_req_out(ext_rd_req_out), .ext_wr_req_out(ext_wr_req_out),
    .done_out(done_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  localparam int TMO = 15;

  typedef struct {
    int   opc;
    bit   err;
    int   lat, nwe, nflag, nseg, nrd, nwr;
    int   we_mux, we_adr, we_data, we_op, segv;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, got, got, want, want, $time);
  endtask

  // Instruction-level prediction: counts of each action and retire latency
  // (cycles from acceptance edge), given the cycle d of the wait state in
  // which the ALU result or external ack is presented.
  function automatic exp_t model(int opc, int a, int b, int op, int imm, int d);
    exp_t e;
    e = '{opc: opc, err: 0, lat: 1, nwe: 0, nflag: 0, nseg: 0, nrd: 0, nwr: 0,
          we_mux: 0, we_adr: a, we_data: 0, we_op: op, segv: 0};
    case (opc)
      0: ;
      1: begin
        e.nwe = 1; e.nflag = 1; e.we_mux = 2;
        if (op >= 128) begin
          if (d <= TMO) begin e.nwe = 2; e.lat = 2 + d; end
          else begin e.err = 1; e.lat = 2 + TMO; end
        end
      end
      2: begin e.nwe = 1; e.we_mux = 1; e.we_data = imm; end
      3: e.nflag = 1;
      4: begin e.nseg = 1; e.segv = b; end
      5: if (d <= TMO) begin e.nwe = 1; e.we_mux = 3; e.nrd = d + 1; e.lat = 2 + d; end
         else begin e.err = 1; e.nrd = TMO; e.lat = 2 + TMO; end
      6: if (d <= TMO) begin e.nwr = d + 1; e.lat = 2 + d; end
         else begin e.err = 1; e.nwr = TMO; e.lat = 2 + TMO; end
      default: e.err = 1;
    endcase
    return e;
  endfunction

  // Monitor: tracks each accepted instruction until it retires.
  bit busy = 0, pend = 0;
  int lat, nwe, nflag, nseg, nrd, nwr, we_mux, we_adr, we_data, we_op, segv;
  always @(negedge clk) begin
    if (s_reset) begin
      busy = 0; pend = 0;
    end else begin
      if (pend) begin
        busy = 1; pend = 0;
        lat = 0; nwe = 0; nflag = 0; nseg = 0; nrd = 0; nwr = 0;
        we_mux = 0; we_adr = 0; we_data = 0; we_op = 0; segv = 0;
      end
      if (busy) begin
        lat++;
        if (reg_file_we_out) begin
          nwe++; we_mux = alu_mux_sel_out; we_adr = a_adr_out;
          we_data = data_instr_out; we_op = alu_op_out;
        end
        if (flag_reg_ce_out) nflag++;
        if (seg_reg_load_out) begin nseg++; segv = seg_reg_out; end
        if (ext_rd_req_out) nrd++;
        if (ext_wr_req_out) nwr++;
        if (instr_ready_out) chk("ready_while_busy", 1, 0);
        if (done_out && err_out) chk("done_and_err", 1, 0);
        if (done_out || err_out) begin
          busy = 0;
          if (exp_q.size() == 0) chk("unexpected_retire", 1, 0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("err", err_out, e.err);
            chk("latency", lat, e.lat);
            chk("we_count", nwe, e.nwe);
            chk("flag_count", nflag, e.nflag);
            chk("seg_count", nseg, e.nseg);
            chk("rd_req_cycles", nrd, e.nrd);
            chk("wr_req_cycles", nwr, e.nwr);
            if (e.nwe > 0) begin
              chk("we_mux", we_mux, e.we_mux);
              chk("we_adr", we_adr, e.we_adr);
            end
            if (e.opc == 1) chk("alu_op", we_op, e.we_op);
            if (e.opc == 2) chk("ldi_data", we_data, e.we_data);
            if (e.nseg > 0) chk("seg_val", segv, e.segv);
          end
        end
      end else begin
        chk("idle_quiet", {reg_file_we_out, flag_reg_ce_out, seg_reg_load_out,
            ext_rd_req_out, ext_wr_req_out, done_out, err_out, alu_mux_sel_out}, 0);
        if (instr_valid_in && instr_ready_out) pend = 1;
      end
    end
  end

  // Issue one instruction; d is the wait-state cycle that gets valid/ack
  // (d > TMO means never, forcing a timeout).
  task automatic issue(int opc, int a, int b, int op, int imm, int d);
    bit waits;
    bit done_ok;
    exp_q.push_back(model(opc, a, b, op, imm, d));
    @(posedge clk); #1;
    instr_valid_in = 1; instr_opc_in = 4'(opc); instr_a_in = 4'(a);
    instr_b_in = 4'(b); instr_alu_op_in = 8'(op); instr_imm_in = 16'(imm);
    alu_valid_in = 0; ext_ack_in = 0;
    @(posedge clk); #1;
    instr_valid_in = 0;
    waits = (opc == 1 && op >= 128) || opc == 5 || opc == 6;
    if (waits && d <= TMO) begin
      @(posedge clk);
      repeat (d) @(posedge clk);
      #1;
      if (opc == 1) alu_valid_in = 1; else ext_ack_in = 1;
      @(posedge clk); #1;
      alu_valid_in = 0; ext_ack_in = 0;
    end
    done_ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_ready_out) begin done_ok = 1; break; end
    end
    if (!done_ok) chk("ready_timeout", 0, 1);
    // Idle gap with stray valid/ack that must be ignored.
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      alu_valid_in = 1'($urandom); ext_ack_in = 1'($urandom);
    end
  endtask

  initial begin
    s_reset = 1; instr_valid_in = 0; instr_opc_in = 0; instr_a_in = 0; instr_b_in = 0;
    instr_alu_op_in = 0; instr_imm_in = 0; alu_valid_in = 0; ext_ack_in = 0;
    repeat (3) @(posedge clk);
    #1 s_reset = 0;
    @(negedge clk);
    chk("reset_ready", instr_ready_out, 1);
    chk("reset_outputs", {a_adr_out, b_adr_out, alu_op_out, reg_file_we_out, flag_reg_ce_out,
        alu_mux_sel_out, data_instr_out, seg_reg_out, seg_reg_load_out, ext_rd_req_out,
        ext_wr_req_out, done_out, err_out}, 0);

    // Directed cases, including timeout boundaries.
    issue(2, 3, 0, 0, 16'hBEEF, 0);
    issue(1, 2, 4, 8'h05, 0, 0);
    issue(1, 2, 4, 8'h85, 0, 5);
    issue(5, 7, 1, 0, 0, 99);
    issue(4'hA, 1, 2, 0, 0, 0);
    issue(4, 0, 9, 0, 0, 0);
    issue(3, 1, 2, 8'h11, 0, 0);
    issue(0, 0, 0, 0, 0, 0);
    issue(5, 6, 0, 0, 0, 14);
    issue(5, 6, 0, 0, 0, 15);
    issue(6, 5, 0, 0, 0, 15);
    issue(6, 5, 0, 0, 0, 16);
    issue(1, 9, 3, 8'hC2, 0, 15);
    issue(1, 9, 3, 8'hC2, 0, 20);
    issue(5, 4, 0, 0, 0, 0);

    // Reset in the middle of a long ALU wait.
    @(posedge clk); #1;
    instr_valid_in = 1; instr_opc_in = 1; instr_a_in = 5; instr_b_in = 6;
    instr_alu_op_in = 8'h90; alu_valid_in = 0; ext_ack_in = 0;
    @(posedge clk); #1 instr_valid_in = 0;
    repeat (4) @(posedge clk);
    #1 s_reset = 1; alu_valid_in = 1;
    @(negedge clk);
    chk("abort_no_side_effect", {reg_file_we_out, done_out, err_out}, 0);
    @(posedge clk); #1 s_reset = 0; alu_valid_in = 0;
    @(negedge clk);
    chk("abort_ready", instr_ready_out, 1);
    chk("abort_outputs", {a_adr_out, alu_op_out, alu_mux_sel_out, reg_file_we_out}, 0);
    @(posedge clk); #1 alu_valid_in = 1;
    @(posedge clk); #1 alu_valid_in = 0;
    @(negedge clk);
    chk("stray_valid_ignored", {instr_ready_out, reg_file_we_out, done_out}, 3'b100);

    // Random instruction mix.
    for (int n = 0; n < 150; n++) begin
      int r, opc, op;
      r = $urandom_range(0, 21);
      opc = (r < 16) ? r : (r - 15);
      op = $urandom_range(0, 255);
      issue(opc, $urandom_range(0, 15), $urandom_range(0, 15), op,
            $urandom_range(0, 65535), $urandom_range(0, 18));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
